// File: rtl/timing_config_ctrl_if.sv
// Configuration bus between a requester and the timing configuration controller.
// The requester drives the cfg_* request fields; the controller returns the
// programming strobe, target select, value and status.
interface timing_config_ctrl_if;
  logic       cfg_start;
  logic [3:0] cfg_base;
  logic [3:0] cfg_ext;
  logic [3:0] cfg_yel;
  logic       prog_sync;
  logic [1:0] time_parameter_selector;
  logic [3:0] time_value;
  logic       busy;
  logic       done;
  logic       cfg_error;
  logic [7:0] load_count;

  modport master (
    output cfg_start, cfg_base, cfg_ext, cfg_yel,
    input  prog_sync, time_parameter_selector, time_value,
    input  busy, done, cfg_error, load_count
  );

  modport slave (
    input  cfg_start, cfg_base, cfg_ext, cfg_yel,
    output prog_sync, time_parameter_selector, time_value,
    output busy, done, cfg_error, load_count
  );
endinterface

// File: rtl/timing_config_ctrl.sv
// Timing configuration controller: captures a BASE/EXT/YELLOW interval set,
// validates it, writes the three values one per cycle to the parameter store,
// holds the program strobe for HOLD_CYCLES, then reports completion.
// All outputs are decoded from registered state only.
module timing_config_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MIN_VALUE   = 1
) (
  input  logic clock,
  input  logic reset_n,
  timing_config_ctrl_if.slave bus
);

  localparam logic [3:0] LP_HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_MIN_VALUE = 4'(MIN_VALUE);
  localparam logic [1:0] LP_SEL_NONE  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WR_BASE,
    WR_EXT,
    WR_YEL,
    HOLD,
    DONE,
    ERR
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_base;
  logic [3:0] r_ext;
  logic [3:0] r_yel;
  logic [3:0] r_holdCnt;
  logic [7:0] r_loadCount;
  logic       w_reject;

  logic       w_progSync;
  logic [1:0] w_selector;
  logic [3:0] w_timeValue;
  logic       w_busy;
  logic       w_done;
  logic       w_cfgError;

  assign w_reject = (r_base < LP_MIN_VALUE) || (r_ext < LP_MIN_VALUE) ||
                    (r_yel < LP_MIN_VALUE) || (r_yel > r_base);

  // State register; reset aborts any load in progress
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; cfg_start only matters in IDLE so requests while busy are dropped
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.cfg_start) w_nextState = CHECK;
      CHECK:   w_nextState = w_reject ? ERR : WR_BASE;
      WR_BASE: w_nextState = WR_EXT;
      WR_EXT:  w_nextState = WR_YEL;
      WR_YEL:  w_nextState = HOLD;
      HOLD:    if (r_holdCnt == 4'd0) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      ERR:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Capture the request on acceptance so later input changes cannot disturb the load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_base <= 4'd0;
      r_ext  <= 4'd0;
      r_yel  <= 4'd0;
    end else if ((r_state == IDLE) && bus.cfg_start) begin
      r_base <= bus.cfg_base;
      r_ext  <= bus.cfg_ext;
      r_yel  <= bus.cfg_yel;
    end
  end

  // Hold down-counter, loaded on the way into HOLD so HOLD lasts exactly HOLD_CYCLES
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_holdCnt <= 4'd0;
    end else if (r_state == WR_YEL) begin
      r_holdCnt <= LP_HOLD_LOAD;
    end else if ((r_state == HOLD) && (r_holdCnt != 4'd0)) begin
      r_holdCnt <= r_holdCnt - 4'd1;
    end
  end

  // Successful-load counter, saturating at 255
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_loadCount <= 8'd0;
    end else if ((r_state == DONE) && (r_loadCount != 8'hFF)) begin
      r_loadCount <= r_loadCount + 8'd1;
    end
  end

  // Moore output decode from the registered state and captured values
  always_comb begin
    w_progSync  = 1'b0;
    w_selector  = LP_SEL_NONE;
    w_timeValue = 4'd0;
    w_busy      = (r_state != IDLE);
    w_done      = 1'b0;
    w_cfgError  = 1'b0;
    case (r_state)
      WR_BASE: begin
        w_progSync  = 1'b1;
        w_selector  = 2'd0;
        w_timeValue = r_base;
      end
      WR_EXT: begin
        w_progSync  = 1'b1;
        w_selector  = 2'd1;
        w_timeValue = r_ext;
      end
      WR_YEL: begin
        w_progSync  = 1'b1;
        w_selector  = 2'd2;
        w_timeValue = r_yel;
      end
      HOLD:    w_progSync = 1'b1;
      DONE:    w_done     = 1'b1;
      ERR:     w_cfgError = 1'b1;
      default: ;
    endcase
  end

  assign bus.prog_sync               = w_progSync;
  assign bus.time_parameter_selector = w_selector;
  assign bus.time_value              = w_timeValue;
  assign bus.busy                    = w_busy;
  assign bus.done                    = w_done;
  assign bus.cfg_error               = w_cfgError;
  assign bus.load_count              = r_loadCount;

endmodule

// File: tb/tb_timing_config_ctrl.sv
// Bench for timing_config_ctrl: a transaction-level model turns each accepted
// request into the expected sequence of per-cycle output records, which are
// compared against the DUT one cycle at a time. A second instance with a
// one-cycle hold covers the short-hold boundary.
module tb_timing_config_ctrl;

  localparam int MODEL_HOLD = 4;

  logic clock;
  logic reset_n;

  timing_config_ctrl_if if0 ();
  timing_config_ctrl_if if1 ();

  timing_config_ctrl dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if0.slave)
  );

  timing_config_ctrl #(.HOLD_CYCLES(1), .MIN_VALUE(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  logic [9:0] expQ[$];
  logic [9:0] curExp;
  bit         curIdle;
  int         modelLoads;
  logic       tStart;
  logic [3:0] tBase, tExt, tYel;

  // Record layout: {prog_sync, selector[1:0], value[3:0], busy, done, cfg_error}
  function automatic logic [9:0] rec(input logic ps, input logic [1:0] sel,
                                     input logic [3:0] val, input logic bsy,
                                     input logic dn, input logic er);
    return {ps, sel, val, bsy, dn, er};
  endfunction

  function automatic logic [15:0] obs0();
    return {6'd0, if0.prog_sync, if0.time_parameter_selector, if0.time_value,
            if0.busy, if0.done, if0.cfg_error};
  endfunction

  function automatic logic [15:0] satLoads();
    return 16'((modelLoads > 255) ? 255 : modelLoads);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [3:0] b,
                               input logic [3:0] e, input logic [3:0] y);
    tStart = s; tBase = b; tExt = e; tYel = y;
    if0.cfg_start = s;
    if0.cfg_base  = b;
    if0.cfg_ext   = e;
    if0.cfg_yel   = y;
  endtask

  task automatic modelReset();
    expQ.delete();
    curExp     = rec(1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    curIdle    = 1'b1;
    modelLoads = 0;
  endtask

  // Advance the model across one rising edge
  task automatic modelEdge();
    if (curIdle && tStart) begin
      expQ.push_back(rec(1'b0, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0));
      if (tBase < 1 || tExt < 1 || tYel < 1 || tYel > tBase) begin
        expQ.push_back(rec(1'b0, 2'd3, 4'd0, 1'b1, 1'b0, 1'b1));
      end else begin
        expQ.push_back(rec(1'b1, 2'd0, tBase, 1'b1, 1'b0, 1'b0));
        expQ.push_back(rec(1'b1, 2'd1, tExt, 1'b1, 1'b0, 1'b0));
        expQ.push_back(rec(1'b1, 2'd2, tYel, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < MODEL_HOLD; i++)
          expQ.push_back(rec(1'b1, 2'd3, 4'd0, 1'b1, 1'b0, 1'b0));
        expQ.push_back(rec(1'b0, 2'd3, 4'd0, 1'b1, 1'b1, 1'b0));
      end
    end
    if (expQ.size() == 0) begin
      curExp  = rec(1'b0, 2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
      curIdle = 1'b1;
    end else begin
      curExp  = expQ.pop_front();
      curIdle = 1'b0;
      if (curExp[1]) modelLoads++;
    end
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput(tag, obs0(), {6'd0, curExp});
    if (curIdle) checkOutput({tag, "_cnt"}, {8'd0, if0.load_count}, satLoads());
  endtask

  initial begin
    logic [2:0] dutOne;
    int         guard;

    reset_n = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0);
    if1.cfg_start = 1'b0;
    if1.cfg_base  = 4'd0;
    if1.cfg_ext   = 4'd0;
    if1.cfg_yel   = 4'd0;
    modelReset();
    #3;
    checkOutput("reset_out", obs0(), {6'd0, curExp});
    checkOutput("reset_cnt", {8'd0, if0.load_count}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Nominal load accepted on the very first edge after reset, with a busy-time start
    applyStimulus(1'b1, 4'd6, 4'd3, 4'd2);
    stepCycle("nom");
    applyStimulus(1'b0, 4'd6, 4'd3, 4'd2);
    stepCycle("nom");
    applyStimulus(1'b1, 4'd9, 4'd3, 4'd2);
    stepCycle("busy_ign");
    applyStimulus(1'b0, 4'd9, 4'd3, 4'd2);
    for (int i = 0; i < 10; i++) stepCycle("nom");
    checkOutput("nom_cnt", {8'd0, if0.load_count}, 16'd1);

    // Rejects: yellow longer than base, then a zero extension
    applyStimulus(1'b1, 4'd6, 4'd3, 4'd7);
    stepCycle("rej_yel");
    applyStimulus(1'b0, 4'd6, 4'd3, 4'd7);
    for (int i = 0; i < 3; i++) stepCycle("rej_yel");
    applyStimulus(1'b1, 4'd6, 4'd0, 4'd2);
    stepCycle("rej_ext");
    applyStimulus(1'b0, 4'd6, 4'd0, 4'd2);
    for (int i = 0; i < 3; i++) stepCycle("rej_ext");
    checkOutput("rej_cnt", {8'd0, if0.load_count}, 16'd1);

    // Reset in the middle of HOLD: everything drops at once, no done pulse
    applyStimulus(1'b1, 4'd6, 4'd3, 4'd2);
    stepCycle("rst_mid");
    applyStimulus(1'b0, 4'd6, 4'd3, 4'd2);
    for (int i = 0; i < 4; i++) stepCycle("rst_mid");
    @(posedge clock);
    modelEdge();
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_mid_out", obs0(), {6'd0, curExp});
    checkOutput("rst_mid_cnt", {8'd0, if0.load_count}, 16'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) stepCycle("post_rst");

    // Randomized requests, biased so both accepts and rejects occur
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 15)),
                    4'($urandom_range(0, 9)));
      stepCycle("rand");
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 12; i++) stepCycle("rand_drain");

    // Saturation: start held high for back-to-back loads
    modelLoads = int'(if0.load_count);
    guard = 0;
    applyStimulus(1'b1, 4'd6, 4'd3, 4'd2);
    while (modelLoads < 262 && guard < 4000) begin
      stepCycle("sat");
      guard++;
    end
    if (guard >= 4000) checkOutput("sat_timeout", 16'd1, 16'd0);
    applyStimulus(1'b0, 4'd6, 4'd3, 4'd2);
    for (int i = 0; i < 12; i++) stepCycle("sat_drain");
    checkOutput("sat_cnt", {8'd0, if0.load_count}, 16'd255);

    // One-cycle hold boundary on the second instance: base = yellow = 1
    if1.cfg_start = 1'b1;
    if1.cfg_base  = 4'd1;
    if1.cfg_ext   = 4'd1;
    if1.cfg_yel   = 4'd1;
    @(posedge clock);
    @(negedge clock);
    if1.cfg_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin
        @(posedge clock);
        @(negedge clock);
      end
      dutOne = {1'(c >= 2 && c <= 5), 1'(c == 6), 1'(c <= 6)};
      checkOutput($sformatf("h1_c%0d", c),
                  {13'd0, if1.prog_sync, if1.done, if1.busy}, {13'd0, dutOne});
      if (c >= 2 && c <= 4)
        checkOutput($sformatf("h1_wr%0d", c),
                    {10'd0, if1.time_parameter_selector, if1.time_value},
                    {10'd0, 2'(c - 2), 4'd1});
    end
    checkOutput("h1_cnt", {8'd0, if1.load_count}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/timing_config_ctrl.md
TIMING_CONFIG_CTRL -- requirements
Module: timing_config_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4 (range 1..15), cycles prog_sync stays high after the last write.
REQ-002 Parameter: MIN_VALUE, default 1, smallest legal interval value.
REQ-003 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: cfg_start  input  1  request to load a new timing set; sampled only in IDLE.
REQ-006 Port: cfg_base / cfg_ext / cfg_yel  input  4 each  requested BASE, EXT and YELLOW interval values.
REQ-007 Port: prog_sync  output  1  program strobe to the timing-parameter store and the light FSM.
REQ-008 Port: time_parameter_selector  output  2  target select: 0=BASE, 1=EXT, 2=YELLOW, 3=no-write.
REQ-009 Port: time_value  output  4  value written to the selected parameter.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse when a load completes.
REQ-012 Port: cfg_error  output  1  one-cycle pulse when a request is rejected.
REQ-013 Port: load_count  output  8  number of successful loads, saturating.

Function
REQ-014 The state machine SHALL have the states IDLE, CHECK, WR_BASE, WR_EXT, WR_YEL, HOLD, DONE and ERR.
REQ-015 All outputs SHALL be Moore outputs of registered state and counters, with no combinational path from any input.
REQ-016 In IDLE, cfg_start=1 SHALL capture cfg_base, cfg_ext and cfg_yel into internal registers and move to CHECK on the same edge.
REQ-017 Changes to the cfg_* inputs after capture SHALL have no effect on the load in progress.
REQ-018 In CHECK, the request SHALL be rejected (next state ERR) if any captured value < MIN_VALUE or if cfg_yel > cfg_base; otherwise the next state is WR_BASE.
REQ-019 ERR SHALL last one cycle, assert cfg_error=1 and prog_sync=0, then return to IDLE; no parameter is written.
REQ-020 WR_BASE, WR_EXT and WR_YEL SHALL each last one cycle with prog_sync=1, selector 0/1/2 respectively, and time_value equal to the matching captured value.
REQ-021 HOLD SHALL last exactly HOLD_CYCLES cycles with prog_sync=1, selector=3 and time_value=0, timed by a 4-bit down-counter loaded on entry.
REQ-022 DONE SHALL last one cycle with done=1 and prog_sync=0, increment load_count (held at 255 once reached), then return to IDLE.
REQ-023 Latency: for cfg_start sampled at edge 0, prog_sync SHALL be high for cycles 2 through 4+HOLD_CYCLES, and done SHALL be high in cycle 5+HOLD_CYCLES.
REQ-024 cfg_start while busy=1 SHALL be ignored and not queued; cfg_start held high continuously SHALL start a new load on the first IDLE cycle after DONE or ERR.
REQ-025 In IDLE and CHECK, prog_sync=0, selector=3 and time_value=0.
REQ-026 done and cfg_error SHALL never be high in the same cycle.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, prog_sync=0, selector=3, time_value=0, busy=0, done=0, cfg_error=0, load_count=0, and clear the captured registers and the hold counter.
REQ-028 Reset asserted mid-load SHALL abort the load with no further strobes; values already written stay written.
REQ-029 After reset_n rises, the first cfg_start SHALL be honoured on the first clock edge.

Verification
REQ-030 Nominal: base=6, ext=3, yel=2, HOLD_CYCLES=4, pulse cfg_start -> writes (sel0,6),(sel1,3),(sel2,2) in cycles 2-4, prog_sync high in cycles 2-8, done in cycle 9, load_count=1.
REQ-031 Reject: yel=7, base=6 -> cfg_error in cycle 2, prog_sync never high, load_count unchanged; repeat with ext=0 -> same result.
REQ-032 Busy ignore: second cfg_start in cycle 3 with base=9 -> no second load starts, and the written BASE value stays 6.
REQ-033 Reset mid-HOLD: drive reset_n low in cycle 6 -> prog_sync=0 and busy=0 immediately, no done pulse, load_count=0.
REQ-034 Saturation: 260 back-to-back valid loads -> load_count=255, and done is still pulsed on each load.
REQ-035 Boundary: base=yel=MIN_VALUE=1, HOLD_CYCLES=1 -> load accepted, prog_sync high in cycles 2-5, done in cycle 6.
